// File: rtl/cam_frame_ram_writer.sv
// cam_frame_ram_writer: packs an 8-bit camera byte stream (with SOF/EOF
// markers) into 16-bit words and writes one frame per arm request into a
// single-port frame RAM at consecutive word addresses starting at BASE_ADDR.
// Reports frame completion, written word count and a sticky overflow flag.
// Optional feature: define CAM_FRAME_CHECKSUM_EN to add the frame_checksum
// output (mod-2^16 sum of all written words).
module cam_frame_ram_writer #(
    parameter int ADDR_W    = 18,
    parameter int MEM_DEPTH = 133081,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eof,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow
`ifdef CAM_FRAME_CHECKSUM_EN
    ,
    output logic [15:0]       frame_checksum
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [7:0]        low_q;          // low byte waiting for its partner
    logic              pend_q;         // low_q holds a valid byte
    logic              discard_q;      // overflowed: drop bytes until EOF
    logic [ADDR_W-1:0] wcnt_q;         // words written so far (offset from BASE)
    logic [ADDR_W-1:0] mem_address_q;
    logic [1:0]        mem_be_q;
    logic              mem_write_q;
    logic [15:0]       mem_wdata_q;
    logic              frame_done_q;
    logic [ADDR_W-1:0] word_count_q;
    logic              overflow_q;
`ifdef CAM_FRAME_CHECKSUM_EN
    logic [15:0]       checksum_q;
`endif

    logic              accept_d;
    logic              room_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] wcnt_d;

    // Byte handshake, free-space check and next write address/count
    always_comb begin
        accept_d  = pix_valid & pix_ready;
        room_d    = (wcnt_q < DEPTH_C);
        wr_addr_d = BASE_C + wcnt_q;
        wcnt_d    = wcnt_q + 1'b1;
    end

    assign pix_ready      = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE);
    assign busy           = (state_q != S_IDLE);
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_be_q;
    assign mem_write      = mem_write_q;
    assign mem_chipselect = mem_write_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_clken      = 1'b1;
    assign frame_done     = frame_done_q;
    assign word_count     = word_count_q;
    assign overflow       = overflow_q;
`ifdef CAM_FRAME_CHECKSUM_EN
    assign frame_checksum = checksum_q;
`endif

    // Capture FSM with registered RAM-side and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            low_q         <= 8'h00;
            pend_q        <= 1'b0;
            discard_q     <= 1'b0;
            wcnt_q        <= '0;
            mem_address_q <= BASE_C;
            mem_be_q      <= 2'b00;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= 16'h0000;
            frame_done_q  <= 1'b0;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
`ifdef CAM_FRAME_CHECKSUM_EN
            checksum_q    <= 16'h0000;
`endif
        end else begin
            // Strobes are single-cycle unless re-issued below
            mem_write_q  <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q       <= S_WAIT_SOF;
                        overflow_q    <= 1'b0;
                        wcnt_q        <= '0;
                        pend_q        <= 1'b0;
                        discard_q     <= 1'b0;
                        mem_address_q <= BASE_C;
`ifdef CAM_FRAME_CHECKSUM_EN
                        checksum_q    <= 16'h0000;
`endif
                    end
                end

                S_WAIT_SOF: begin
                    if (accept_d && pix_sof) begin
                        low_q   <= pix_data;
                        pend_q  <= 1'b1;
                        state_q <= pix_eof ? S_FLUSH : S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (accept_d) begin
                        if (discard_q) begin
                            // Overflowed frame: swallow bytes until EOF
                            if (pix_eof) begin
                                state_q <= S_DONE;
                            end
                        end else if (pix_sof) begin
                            // Restart: the new SOF byte becomes word 0's low byte
                            low_q  <= pix_data;
                            pend_q <= 1'b1;
                            wcnt_q <= '0;
                            if (pix_eof) begin
                                state_q <= S_FLUSH;
                            end
                        end else if (!pend_q) begin
                            low_q  <= pix_data;
                            pend_q <= 1'b1;
                            if (pix_eof) begin
                                state_q <= S_FLUSH;
                            end
                        end else begin
                            pend_q <= 1'b0;
                            if (room_d) begin
                                mem_write_q   <= 1'b1;
                                mem_be_q      <= 2'b11;
                                mem_address_q <= wr_addr_d;
                                mem_wdata_q   <= {pix_data, low_q};
                                wcnt_q        <= wcnt_d;
`ifdef CAM_FRAME_CHECKSUM_EN
                                checksum_q    <= checksum_q + {pix_data, low_q};
`endif
                                if (pix_eof) begin
                                    state_q <= S_DONE;
                                end
                            end else begin
                                overflow_q <= 1'b1;
                                if (pix_eof) begin
                                    state_q <= S_DONE;
                                end else begin
                                    discard_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    // Odd-length frame: write the lone low byte with high lane off
                    pend_q  <= 1'b0;
                    state_q <= S_DONE;
                    if (room_d) begin
                        mem_write_q   <= 1'b1;
                        mem_be_q      <= 2'b01;
                        mem_address_q <= wr_addr_d;
                        mem_wdata_q   <= {8'h00, low_q};
                        wcnt_q        <= wcnt_d;
`ifdef CAM_FRAME_CHECKSUM_EN
                        checksum_q    <= checksum_q + {8'h00, low_q};
`endif
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    word_count_q <= wcnt_q;
                    frame_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_ram_writer.sv
// Testbench for cam_frame_ram_writer: table-driven frames on a full-size
// instance and a MEM_DEPTH=4 instance, plus a reset-mid-frame sequence.
module tb_cam_frame_ram_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, arm0, arm1, pix_valid, pix_sof, pix_eof;
    logic [7:0]  pix_data;

    logic        r0, r1, be_dummy;
    logic [17:0] a0, a1, wc0, wc1;
    logic [1:0]  be0, be1;
    logic        cs0, cs1, we0, we1, ck0, ck1, busy0, busy1, fd0, fd1, ov0, ov1;
    logic [15:0] wd0, wd1;
`ifdef CAM_FRAME_CHECKSUM_EN
    logic [15:0] sum0, sum1;
`endif

    cam_frame_ram_writer dut0 (
`ifdef CAM_FRAME_CHECKSUM_EN
        .frame_checksum(sum0),
`endif
        .clk(clk), .reset(reset), .arm(arm0),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .pix_ready(r0), .mem_address(a0), .mem_byteenable(be0), .mem_chipselect(cs0),
        .mem_write(we0), .mem_writedata(wd0), .mem_clken(ck0), .busy(busy0),
        .frame_done(fd0), .word_count(wc0), .overflow(ov0)
    );

    cam_frame_ram_writer #(.MEM_DEPTH(4)) dut1 (
`ifdef CAM_FRAME_CHECKSUM_EN
        .frame_checksum(sum1),
`endif
        .clk(clk), .reset(reset), .arm(arm1),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .pix_ready(r1), .mem_address(a1), .mem_byteenable(be1), .mem_chipselect(cs1),
        .mem_write(we1), .mem_writedata(wd1), .mem_clken(ck1), .busy(busy1),
        .frame_done(fd1), .word_count(wc1), .overflow(ov1)
    );

    typedef struct packed {
        logic             big;     // 1: run on the MEM_DEPTH=4 instance
        logic [4:0]       nb;
        logic [15:0][9:0] bytes;   // {sof, eof, data}
        logic [3:0]       nw;
        logic [7:0][35:0] wr;      // {addr, data, byteenable}
        logic [17:0]      wc;
        logic             ovf;
        logic [4:0]       arm_at;  // byte index carrying a stray arm; 31 = none
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    int          total = 0;
    int          bad = 0;
    int          cur_vec = -1;
    logic        sel = 1'b0;
    logic [17:0] prev_wc[2];
    logic [37:0] wq[$];

    // Write monitor: every cycle with a strobe becomes one queue entry
    always @(negedge clk) begin
        if (we0 | cs0) wq.push_back({cs0, we0, a0, wd0, be0});
        if (we1 | cs1) wq.push_back({cs1, we1, a1, wd1, be1});
    end

    function automatic logic [9:0] B(input logic s, input logic e, input logic [7:0] d);
        return {s, e, d};
    endfunction

    function automatic logic [35:0] W(input int addr, input logic [15:0] d, input logic [1:0] be);
        return {18'(addr), d, be};
    endfunction

    function automatic logic cur_ready();  return sel ? r1 : r0;       endfunction
    function automatic logic cur_busy();   return sel ? busy1 : busy0; endfunction
    function automatic logic cur_fd();     return sel ? fd1 : fd0;     endfunction
    function automatic logic cur_ovf();    return sel ? ov1 : ov0;     endfunction
    function automatic logic [17:0] cur_wc(); return sel ? wc1 : wc0;  endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic pulse_arm();
        if (sel) arm1 = 1'b1; else arm0 = 1'b1;
        @(posedge clk); #1;
        arm0 = 1'b0; arm1 = 1'b0;
    endtask

    task automatic send(input logic [9:0] b, input logic arm_too, output int stalls);
        pix_sof = b[9]; pix_eof = b[8]; pix_data = b[7:0]; pix_valid = 1'b1;
        if (arm_too) begin
            if (sel) arm1 = 1'b1; else arm0 = 1'b1;
        end
        stalls = 0;
        @(negedge clk);
        while (!cur_ready() && stalls < 10) begin
            stalls++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
        arm0 = 1'b0; arm1 = 1'b0;
    endtask

    task automatic wait_done(input logic [17:0] exp_wc, input logic exp_ovf);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cur_fd()) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", 64'(got), 64'd1);
        if (got) begin
            chk("word_count", 64'(cur_wc()), 64'(exp_wc));
            chk("overflow", 64'(cur_ovf()), 64'(exp_ovf));
            @(negedge clk);
            chk("frame_done_width", 64'(cur_fd()), 64'd0);
            chk("busy_idle", 64'(cur_busy()), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        int   s, st;
        v = vecs[i];
        cur_vec = i;
        sel = v.big;
        wq.delete();
        pulse_arm();
        chk("busy_after_arm", 64'(cur_busy()), 64'd1);
        chk("wc_hold_on_arm", 64'(cur_wc()), 64'(prev_wc[sel]));
        chk("ovf_clear_on_arm", 64'(cur_ovf()), 64'd0);
        st = 0;
        for (int j = 0; j < int'(v.nb); j++) begin
            send(v.bytes[j], (j == int'(v.arm_at)), s);
            st += s;
        end
        chk("ready_stalls", 64'(st), 64'd0);
        wait_done(v.wc, v.ovf);
        chk("num_writes", 64'(wq.size()), 64'(v.nw));
        for (int k = 0; k < int'(v.nw); k++) begin
            if (k < wq.size()) chk("write_word", 64'(wq[k]), 64'({2'b11, v.wr[k]}));
        end
        $display("vec %0d: dut%0d writes=%0d word_count=%0d overflow=%0b",
                 i, sel, wq.size(), cur_wc(), cur_ovf());
        prev_wc[sel] = v.wc;
    endtask

    task automatic fill_vectors();
        for (int i = 0; i < NV; i++) begin
            vecs[i] = '0;
            vecs[i].arm_at = 5'd31;
        end
        // Even-length frame
        vecs[0].nb = 4;
        vecs[0].bytes[0] = B(1, 0, 8'h11); vecs[0].bytes[1] = B(0, 0, 8'h22);
        vecs[0].bytes[2] = B(0, 0, 8'h33); vecs[0].bytes[3] = B(0, 1, 8'h44);
        vecs[0].nw = 2; vecs[0].wr[0] = W(0, 16'h2211, 2'b11); vecs[0].wr[1] = W(1, 16'h4433, 2'b11);
        vecs[0].wc = 2;
        // Odd-length frame ends in a flush word
        vecs[1].nb = 3;
        vecs[1].bytes[0] = B(1, 0, 8'hAA); vecs[1].bytes[1] = B(0, 0, 8'hBB);
        vecs[1].bytes[2] = B(0, 1, 8'hCC);
        vecs[1].nw = 2; vecs[1].wr[0] = W(0, 16'hBBAA, 2'b11); vecs[1].wr[1] = W(1, 16'h00CC, 2'b01);
        vecs[1].wc = 2;
        // Bytes before SOF are dropped
        vecs[2].nb = 4;
        vecs[2].bytes[0] = B(0, 0, 8'h01); vecs[2].bytes[1] = B(0, 0, 8'h02);
        vecs[2].bytes[2] = B(1, 0, 8'h10); vecs[2].bytes[3] = B(0, 1, 8'h20);
        vecs[2].nw = 1; vecs[2].wr[0] = W(0, 16'h2010, 2'b11);
        vecs[2].wc = 1;
        // Mid-frame SOF restarts at BASE
        vecs[3].nb = 5;
        vecs[3].bytes[0] = B(1, 0, 8'h11); vecs[3].bytes[1] = B(0, 0, 8'h22);
        vecs[3].bytes[2] = B(0, 0, 8'h33); vecs[3].bytes[3] = B(1, 0, 8'h44);
        vecs[3].bytes[4] = B(0, 1, 8'h55);
        vecs[3].nw = 2; vecs[3].wr[0] = W(0, 16'h2211, 2'b11); vecs[3].wr[1] = W(0, 16'h5544, 2'b11);
        vecs[3].wc = 1;
        // Single byte with SOF and EOF goes straight to flush
        vecs[4].nb = 1;
        vecs[4].bytes[0] = B(1, 1, 8'h7E);
        vecs[4].nw = 1; vecs[4].wr[0] = W(0, 16'h007E, 2'b01);
        vecs[4].wc = 1;
        // Stray arm mid-frame is ignored
        vecs[5] = vecs[0];
        vecs[5].arm_at = 5'd1;
        // 12-byte frame into a 4-word RAM: overflow, discard until EOF
        vecs[6].big = 1'b1; vecs[6].nb = 12; vecs[6].nw = 4; vecs[6].wc = 4; vecs[6].ovf = 1'b1;
        for (int j = 0; j < 12; j++) vecs[6].bytes[j] = B(j == 0, j == 11, 8'(j + 1));
        for (int k = 0; k < 4; k++) vecs[6].wr[k] = W(k, {8'(2 * k + 2), 8'(2 * k + 1)}, 2'b11);
        // Exactly fills the 4-word RAM: no overflow
        vecs[7].big = 1'b1; vecs[7].nb = 8; vecs[7].nw = 4; vecs[7].wc = 4; vecs[7].ovf = 1'b0;
        for (int j = 0; j < 8; j++) vecs[7].bytes[j] = B(j == 0, j == 7, 8'(8'hA0 + j));
        for (int k = 0; k < 4; k++) vecs[7].wr[k] = W(k, {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)}, 2'b11);
        // Flush word would land past the end: suppressed, overflow
        vecs[8].big = 1'b1; vecs[8].nb = 9; vecs[8].nw = 4; vecs[8].wc = 4; vecs[8].ovf = 1'b1;
        for (int j = 0; j < 9; j++) vecs[8].bytes[j] = B(j == 0, j == 8, 8'(8'hB0 + j));
        for (int k = 0; k < 4; k++) vecs[8].wr[k] = W(k, {8'(8'hB1 + 2 * k), 8'(8'hB0 + 2 * k)}, 2'b11);
    endtask

    task automatic check_reset_values();
        chk("rst_ready0", 64'(r0), 64'd0);   chk("rst_addr0", 64'(a0), 64'd0);
        chk("rst_be0", 64'(be0), 64'd0);     chk("rst_cs0", 64'(cs0), 64'd0);
        chk("rst_we0", 64'(we0), 64'd0);     chk("rst_wd0", 64'(wd0), 64'd0);
        chk("rst_clken0", 64'(ck0), 64'd1);  chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_fd0", 64'(fd0), 64'd0);     chk("rst_wc0", 64'(wc0), 64'd0);
        chk("rst_ovf0", 64'(ov0), 64'd0);
        chk("rst_ready1", 64'(r1), 64'd0);   chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_clken1", 64'(ck1), 64'd1);  chk("rst_we1", 64'(we1), 64'd0);
    endtask

    initial begin
        int s;
        reset = 1'b1; arm0 = 1'b0; arm1 = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = 8'h00;
        be_dummy = 1'b0;
        prev_wc[0] = '0; prev_wc[1] = '0;
        fill_vectors();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) apply_vec(i);

        // Reset while a low byte is pending: no flush, clean restart
        cur_vec = 100;
        sel = 1'b0;
        pulse_arm();
        send(B(1, 0, 8'h11), 1'b0, s);
        send(B(0, 0, 8'h22), 1'b0, s);
        send(B(0, 0, 8'h33), 1'b0, s);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", 64'(we0), 64'd0);
        chk("midrst_cs", 64'(cs0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_addr", 64'(a0), 64'd0);
        chk("midrst_ready", 64'(r0), 64'd0);
        reset = 1'b0;
        wq.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_flush", 64'(wq.size()), 64'd0);
        $display("seq reset-mid-frame: writes after reset=%0d", wq.size());
        prev_wc[0] = '0; prev_wc[1] = '0;
        apply_vec(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_frame_ram_writer.md
Name: cam_frame_ram_writer

Overview:
- Upstream stage of the 16-bit single-port on-chip frame RAM (18-bit word address, 2-bit byteenable).
- Accepts an 8-bit camera pixel byte stream with start-of-frame and end-of-frame markers, packs byte pairs into 16-bit words, and writes one frame per arm request at consecutive word addresses.
- Reports completion, word count and overflow to the Nios-side control logic.

Parameters:
- ADDR_W, 18: RAM word-address width.
- MEM_DEPTH, 133081: number of writable words; the last valid address is BASE_ADDR+MEM_DEPTH-1.
- BASE_ADDR, 0: word address of the first word of a frame.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle request to capture the next frame.
- pix_data  in  8  pixel byte.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_sof  in  1  qualifies the byte as the first byte of a frame.
- pix_eof  in  1  qualifies the byte as the last byte of a frame.
- pix_ready  out  1  writer accepts a byte this cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  2  RAM byte lanes; bit0 is writedata[7:0].
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  16  RAM write data.
- mem_clken  out  1  RAM clock enable.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle completion pulse.
- word_count  out  ADDR_W  words written in the last completed frame.
- overflow  out  1  sticky; last frame exceeded MEM_DEPTH.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0 except mem_clken=1 and mem_address=BASE_ADDR. State is IDLE and the byte-pending flag is cleared.
- Reset mid-frame: the write strobe drops at the reset edge. No partial word is flushed.
- Byte acceptance: a byte is accepted when pix_valid & pix_ready. pix_ready is 1 in WAIT_SOF and CAPTURE, and 0 in all other states.
- IDLE: arm moves the block to WAIT_SOF. On this transition, clear overflow and the address counter; word_count keeps its value.
- WAIT_SOF:
  - Accepted bytes without pix_sof are discarded.
  - An accepted byte with pix_sof is stored as the low byte, and the state moves to CAPTURE.
  - A byte with both pix_sof and pix_eof goes straight to FLUSH.
- CAPTURE, packing:
  - Even-position bytes go to the low byte; odd-position bytes go to the high byte.
  - When the high byte is accepted in cycle N, cycle N+1 presents mem_write=mem_chipselect=1, mem_byteenable=2'b11 and the packed word at the current address.
  - The address increments after each write.
  - At most one write occurs per cycle; a new byte may be accepted during the write cycle.
- CAPTURE, end of frame:
  - pix_eof on a high byte: that word is written, then the state moves to DONE.
  - pix_eof on a low byte: move to FLUSH.
- CAPTURE, pix_sof mid-frame: restart the frame.
  - Discard any pending byte and reset the address to BASE_ADDR.
  - Store the new byte as the low byte and stay in CAPTURE.
  - Writes already issued are not undone.
- FLUSH: one write with mem_byteenable=2'b01 and the high byte 0, then go to DONE.
- Overflow: if a write would target the word at offset MEM_DEPTH:
  - Suppress the write and set overflow.
  - Keep pix_ready=1 and discard bytes until pix_eof, then go to DONE.
  - The address saturates; there is no wrap-around.
- DONE:
  - word_count <= number of words actually written (partial flush word counts as 1; maximum MEM_DEPTH).
  - frame_done=1 for one cycle, then return to IDLE.
- arm outside IDLE is ignored.
- mem_chipselect equals mem_write. Outside write cycles, mem_writedata holds its last value.

Optional Feature:
- Macro: CAM_FRAME_CHECKSUM_EN.
- With the macro defined:
  - Add output frame_checksum[15:0].
  - It is the modulo-2^16 sum of every 16-bit word actually written, with the flush word's high byte counted as 0.
  - It is cleared on arm and valid when frame_done is asserted; reset value 0.
- Without the macro: the port and the adder are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then arm, then bytes 0x11(sof),0x22,0x33,0x44(eof) -> two writes: addr 0 data 0x2211 be 11, then addr 1 data 0x4433. word_count=2, frame_done one pulse, overflow=0, checksum 0x6644.
- Three-byte frame 0xAA(sof),0xBB,0xCC(eof) -> addr 0 0xBBAA be 11, then addr 1 0x00CC be 01. word_count=2.
- Bytes before sof (0x01,0x02), then 0x10(sof),0x20(eof) -> only addr 0 0x2010 written; the pre-sof bytes produce no write.
- MEM_DEPTH=4 with a 12-byte frame -> 4 writes at addresses 0..3, overflow=1, word_count=4, pix_ready stays 1 until eof, then frame_done.
- Mid-frame sof after 3 bytes, then 2 more bytes ending in eof -> first word at addr 0 written, the restart rewrites addr 0 with the new pair, word_count=1.
- Reset asserted during CAPTURE with a pending low byte -> mem_write=0 at the next edge, busy=0, mem_address=0, no flush write; a subsequent arm captures normally.
